// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Purpose  : Per-channel push-button conditioning: 2-flop synchronizer,
//            polarity normalisation, debounce, press/release edge pulses,
//            and a hold FSM that emits a long-press pulse followed by
//            periodic auto-repeat pulses while the button stays held.
// Revision : 1.0  initial release
// ============================================================================
module button_conditioner #(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = 800000,
    parameter int ACTIVE_LOW      = 1,
    parameter int HOLD_CYCLES     = 40000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_raw,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] long_pulse,
    output logic [N_CH-1:0] repeat_pulse
);

    // Counter widths: each counter only ever reaches its terminal value
    // (parameter - 1) before clearing, so it never wraps.
    localparam int c_DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int c_REP_W  = $clog2(REPEAT_CYCLES + 1);

    localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [c_REP_W-1:0]  c_REP_LAST  = c_REP_W'(REPEAT_CYCLES - 1);

    // Raw pin level that corresponds to "not pressed".
    localparam logic c_RELEASED = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } hold_state_t;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic                r_sync1;
        logic                r_sync2;
        logic [c_DB_W-1:0]   r_db_cnt;
        logic                r_level;
        logic                r_press;
        logic                r_release;
        logic                w_s;
        logic                w_diff;
        logic                w_toggle;
        logic                w_press_acc;
        logic                w_rel_acc;

        hold_state_t         r_state;
        hold_state_t         w_state_nxt;
        logic [c_HOLD_W-1:0] r_hold_cnt;
        logic [c_HOLD_W-1:0] w_hold_nxt;
        logic [c_REP_W-1:0]  r_rep_cnt;
        logic [c_REP_W-1:0]  w_rep_nxt;
        logic                r_long;
        logic                w_long_nxt;
        logic                r_repeat;
        logic                w_repeat_nxt;

        // Synchronized pressed-level and debounce terminal-count decode.
        assign w_s         = r_sync2 ^ c_RELEASED;
        assign w_diff      = (w_s != r_level);
        assign w_toggle    = w_diff && (r_db_cnt == c_DB_LAST);
        assign w_press_acc = w_toggle && !r_level;
        assign w_rel_acc   = w_toggle &&  r_level;

        // Synchronizer, debounce counter, debounced level and edge pulses.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_sync1   <= c_RELEASED;
                r_sync2   <= c_RELEASED;
                r_db_cnt  <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_sync1   <= btn_raw[i];
                r_sync2   <= r_sync1;
                r_press   <= w_press_acc;
                r_release <= w_rel_acc;
                if (!w_diff) begin
                    r_db_cnt <= '0;
                end else if (w_toggle) begin
                    r_db_cnt <= '0;
                    r_level  <= ~r_level;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end
        end

        // Hold FSM state, counters and long/repeat pulse registers.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state    <= ST_IDLE;
                r_hold_cnt <= '0;
                r_rep_cnt  <= '0;
                r_long     <= 1'b0;
                r_repeat   <= 1'b0;
            end else begin
                r_state    <= w_state_nxt;
                r_hold_cnt <= w_hold_nxt;
                r_rep_cnt  <= w_rep_nxt;
                r_long     <= w_long_nxt;
                r_repeat   <= w_repeat_nxt;
            end
        end

        // Hold FSM next state; an accepted release always beats a
        // long/repeat terminal count on the same edge.
        always_comb begin
            w_state_nxt  = r_state;
            w_hold_nxt   = r_hold_cnt;
            w_rep_nxt    = r_rep_cnt;
            w_long_nxt   = 1'b0;
            w_repeat_nxt = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    w_hold_nxt = '0;
                    w_rep_nxt  = '0;
                    if (w_press_acc) begin
                        w_state_nxt = ST_PRESSED;
                    end
                end
                ST_PRESSED: begin
                    if (w_rel_acc) begin
                        w_state_nxt = ST_IDLE;
                        w_hold_nxt  = '0;
                        w_rep_nxt   = '0;
                    end else if (r_hold_cnt == c_HOLD_LAST) begin
                        w_state_nxt = ST_HELD;
                        w_long_nxt  = 1'b1;
                        w_hold_nxt  = '0;
                        w_rep_nxt   = '0;
                    end else begin
                        w_hold_nxt = r_hold_cnt + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (w_rel_acc) begin
                        w_state_nxt = ST_IDLE;
                        w_hold_nxt  = '0;
                        w_rep_nxt   = '0;
                    end else if (r_rep_cnt == c_REP_LAST) begin
                        w_repeat_nxt = 1'b1;
                        w_rep_nxt    = '0;
                    end else begin
                        w_rep_nxt = r_rep_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_hold_nxt  = '0;
                    w_rep_nxt   = '0;
                end
            endcase
        end

        assign btn_level[i]     = r_level;
        assign press_pulse[i]   = r_press;
        assign release_pulse[i] = r_release;
        assign long_pulse[i]    = r_long;
        assign repeat_pulse[i]  = r_repeat;
    end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_conditioner
// Purpose  : Self-checking bench for button_conditioner. A behavioural model
//            predicts every cycle's outputs into a scoreboard queue; a
//            separate monitor pops and compares after each rising edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_button_conditioner;

    localparam int N_CH  = 2;
    localparam int DB    = 4;
    localparam int HOLD  = 10;
    localparam int REP   = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N_CH-1:0] btn_raw = 2'b11;
    logic [N_CH-1:0] btn_level;
    logic [N_CH-1:0] press_pulse;
    logic [N_CH-1:0] release_pulse;
    logic [N_CH-1:0] long_pulse;
    logic [N_CH-1:0] repeat_pulse;

    button_conditioner #(
        .N_CH            (N_CH),
        .DEBOUNCE_CYCLES (DB),
        .ACTIVE_LOW      (1),
        .HOLD_CYCLES     (HOLD),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_raw       (btn_raw),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .repeat_pulse  (repeat_pulse)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N_CH-1:0] level;
        logic [N_CH-1:0] press;
        logic [N_CH-1:0] rel;
        logic [N_CH-1:0] lng;
        logic [N_CH-1:0] rpt;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cycle  = 0;

    // Model state: raw samples from the previous two edges, how many edges in
    // a row the synchronized level has disagreed with the debounced level,
    // and how many edges have elapsed since the press was accepted.
    bit   m_h1[N_CH];
    bit   m_h2[N_CH];
    bit   m_lvl[N_CH];
    bit   m_active[N_CH];
    int   m_run[N_CH];
    int   m_since[N_CH];

    // Predict the outputs visible after the upcoming rising edge.
    task automatic model_edge(input logic [N_CH-1:0] raw, input logic r);
        exp_t e;
        bit   s;
        e = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (r) begin
                m_h1[c] = 1'b1; m_h2[c] = 1'b1;
                m_lvl[c] = 1'b0; m_active[c] = 1'b0;
                m_run[c] = 0; m_since[c] = 0;
            end else begin
                s = ~m_h2[c];
                m_h2[c] = m_h1[c];
                m_h1[c] = raw[c];
                if (s != m_lvl[c]) begin
                    m_run[c]++;
                    if (m_run[c] == DB) begin
                        m_run[c] = 0;
                        m_lvl[c] = ~m_lvl[c];
                        if (m_lvl[c]) e.press[c] = 1'b1;
                        else          e.rel[c]   = 1'b1;
                    end
                end else begin
                    m_run[c] = 0;
                end
                if (e.press[c]) begin
                    m_active[c] = 1'b1;
                    m_since[c]  = 0;
                end else if (e.rel[c]) begin
                    m_active[c] = 1'b0;
                end else if (m_active[c]) begin
                    m_since[c]++;
                    if (m_since[c] == HOLD)
                        e.lng[c] = 1'b1;
                    else if (m_since[c] > HOLD && ((m_since[c] - HOLD) % REP) == 0)
                        e.rpt[c] = 1'b1;
                end
            end
            e.level[c] = m_lvl[c];
        end
        exp_q.push_back(e);
    endtask

    // Drive one input pattern for n cycles, predicting each edge.
    task automatic step(input logic [N_CH-1:0] raw, input logic r, input int n);
        repeat (n) begin
            @(negedge clk);
            btn_raw = raw;
            rst     = r;
            model_edge(raw, r);
        end
    endtask

    // Monitor: compare every predicted cycle against the DUT outputs.
    always @(posedge clk) begin : mon
        exp_t e;
        exp_t got;
        #1;
        cycle++;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL outputs cycle %0d: got lvl=%b prs=%b rel=%b lng=%b rpt=%b, expected lvl=%b prs=%b rel=%b lng=%b rpt=%b",
                         cycle, got.level, got.press, got.rel, got.lng, got.rpt,
                         e.level, e.press, e.rel, e.lng, e.rpt);
            end
        end
    end

    initial begin : stim
        logic [N_CH-1:0] raw;
        int              left[N_CH];

        // Reset and idle.
        step(2'b11, 1'b1, 2);
        step(2'b11, 1'b0, 5);

        // Clean press and release on channel 0.
        step(2'b10, 1'b0, 12);
        step(2'b11, 1'b0, 12);

        // Bounce: five 3-cycle low glitches.
        repeat (5) begin
            step(2'b10, 1'b0, 3);
            step(2'b11, 1'b0, 3);
        end
        step(2'b11, 1'b0, 8);

        // Long press with auto-repeat.
        step(2'b10, 1'b0, 30);
        step(2'b11, 1'b0, 12);

        // Short press.
        step(2'b10, 1'b0, 8);
        step(2'b11, 1'b0, 12);

        // Both channels together.
        step(2'b00, 1'b0, 10);
        step(2'b11, 1'b0, 12);

        // Reset while held, button still down afterwards.
        step(2'b10, 1'b0, 22);
        step(2'b10, 1'b1, 1);
        step(2'b10, 1'b0, 14);
        step(2'b11, 1'b0, 12);

        // Randomized independent channels with occasional reset.
        raw = 2'b11;
        for (int c = 0; c < N_CH; c++) left[c] = 1;
        for (int k = 0; k < 1500; k++) begin
            for (int c = 0; c < N_CH; c++) begin
                left[c]--;
                if (left[c] <= 0) begin
                    raw[c] = ~raw[c];
                    left[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 30))
                                                          : int'($urandom_range(1, 8));
                end
            end
            step(raw, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, 1);
        end
        step(2'b11, 1'b0, 12);

        // Every prediction must have been consumed by the monitor.
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending predictions, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
